// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller. Generates stall/flush controls for
//            the IF_ID and ID_EX registers, the PC stall and the EX_MEM
//            freeze. It covers three hazard classes:
//              - load-use data hazards (one bubble);
//              - taken branch/jump redirects (two bubbles, the second one
//                squashes the stale synchronous-BRAM fetch);
//              - multi-cycle data-memory/MMIO waits, with a sticky timeout
//                watchdog.
//            No register is ever stalled and flushed in the same cycle.
// Ports    : clk, rst_n (async, active low)
//            id_rs1/id_rs2, id_use_rs1/id_use_rs2 : ID source operands
//            ex_rd, ex_mem_read, ex_redirect       : EX stage status
//            mem_busy                              : MEM stage must hold
//            pc_stall, if_id_stall, if_id_flush,
//            id_ex_stall, id_ex_flush, ex_mem_stall: pipeline controls
//            stall_cycles, flush_events            : perf counters (optional)
//            mem_timeout                           : sticky watchdog flag
//            state_o                               : FSM state for debug
// Options  : `define HAZARD_PERF_CNT_EN adds the 32-bit stall_cycles and
//            flush_events counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int TIMEOUT_W   = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_redirect,
    input  logic        mem_busy,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events,
`endif
    output logic        mem_timeout,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_t;

    // A timeout value wider than the counter can never be reached; in that
    // case the watchdog simply never trips instead of matching a truncated
    // value.
    localparam bit                   TIMEOUT_REACHABLE = ((MEM_TIMEOUT >> TIMEOUT_W) == 0);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_MATCH     = TIMEOUT_W'(MEM_TIMEOUT);

    state_t                 state;
    state_t                 next_state;
    logic                   lu;
    logic                   pc_stall_c;
    logic                   if_id_stall_c;
    logic                   if_id_flush_c;
    logic                   id_ex_stall_c;
    logic                   id_ex_flush_c;
    logic                   ex_mem_stall_c;
    logic                   redirect_start;
    logic [TIMEOUT_W-1:0]   wait_cnt;
    logic [TIMEOUT_W-1:0]   wait_inc;

    // ------------------------------------------------------------------
    // Load-use detection: the load in EX writes a register that the ID
    // instruction actually reads. x0 is never a real dependency.
    // ------------------------------------------------------------------
    always_comb begin
        lu = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_use_rs1 && (ex_rd == id_rs1)) ||
              (id_use_rs2 && (ex_rd == id_rs2)));
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and controls. Priority: mem_busy, then the REDIRECT
    // second bubble, then a new redirect, then load-use.
    // While mem_busy holds, EX is frozen, so a pending ex_redirect stays
    // asserted and is serviced in the first non-busy cycle.
    // ------------------------------------------------------------------
    always_comb begin
        next_state     = ST_RUN;
        pc_stall_c     = 1'b0;
        if_id_stall_c  = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_stall_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_stall_c = 1'b0;
        redirect_start = 1'b0;

        if (mem_busy) begin
            pc_stall_c     = 1'b1;
            if_id_stall_c  = 1'b1;
            id_ex_stall_c  = 1'b1;
            ex_mem_stall_c = 1'b1;
            next_state     = ST_MEM_WAIT;
        end else begin
            case (state)
                ST_REDIRECT: begin
                    // Squash the fetch issued before the redirect landed.
                    if_id_flush_c = 1'b1;
                    next_state    = ST_RUN;
                end
                ST_RUN, ST_MEM_WAIT: begin
                    if (ex_redirect) begin
                        if_id_flush_c  = 1'b1;
                        id_ex_flush_c  = 1'b1;
                        redirect_start = 1'b1;
                        next_state     = ST_REDIRECT;
                    end else if (lu) begin
                        // One bubble; next cycle the load has left EX.
                        pc_stall_c    = 1'b1;
                        if_id_stall_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: recover quietly to RUN.
                    next_state = ST_RUN;
                end
            endcase
        end
    end

    // Controls are forced low for as long as reset is held, even though
    // they are otherwise purely combinational from the inputs.
    assign pc_stall     = rst_n & pc_stall_c;
    assign if_id_stall  = rst_n & if_id_stall_c;
    assign if_id_flush  = rst_n & if_id_flush_c;
    assign id_ex_stall  = rst_n & id_ex_stall_c;
    assign id_ex_flush  = rst_n & id_ex_flush_c;
    assign ex_mem_stall = rst_n & ex_mem_stall_c;
    assign state_o      = state;

    // ------------------------------------------------------------------
    // Memory-wait watchdog: counts consecutive busy edges (saturating),
    // and latches mem_timeout on the edge where the count reaches the
    // limit. It only observes; it never alters the pipeline controls.
    // ------------------------------------------------------------------
    assign wait_inc = (wait_cnt == {TIMEOUT_W{1'b1}}) ? wait_cnt : (wait_cnt + 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (mem_busy) begin
            wait_cnt <= wait_inc;
            if (TIMEOUT_REACHABLE && (wait_inc == TIMEOUT_MATCH)) begin
                mem_timeout <= 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters (wrap modulo 2^32). flush_events counts the
    // first bubble of each redirect only, i.e. one event per redirect.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            if (pc_stall_c) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (redirect_start) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard controller: produces stall/flush controls for the IF_ID and ID_EX pipeline registers, the PC stall, and the EX_MEM freeze.
- Handles three hazard classes:
  - load-use data hazards;
  - taken-branch/jump redirects, with an extra bubble for synchronous instruction BRAM;
  - multi-cycle data-memory/MMIO waits, with a timeout watchdog.
- Sits beside the pipeline registers in the CPU top.
- Never asserts stall and flush on the same register in the same cycle.

## Interface
Parameters:
- TIMEOUT_W, 8: width of the memory-wait watchdog counter.
- MEM_TIMEOUT, 200: number of consecutive MEM_WAIT cycles after which the watchdog trips.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source register indices in ID.
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction reads rs1 / rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle.
- mem_busy  in  1  data memory/MMIO not ready; the MEM stage must hold.
- pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall  out  1 each  pipeline controls.
- mem_timeout  out  1  sticky watchdog flag.
- state_o  out  2  current FSM state, for debug.

## Operation
FSM states:
- RUN (2'd0)
- MEM_WAIT (2'd1)
- REDIRECT (2'd2)
- 2'd3 is illegal and returns to RUN on the next edge.

Load-use hazard:
- `lu = ex_mem_read && ex_rd != 0 && ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2))`

Outputs are combinational from state and inputs. Priority: mem_busy > REDIRECT state > ex_redirect > lu.
- mem_busy=1, any state:
  - Asserts pc_stall, if_id_stall, id_ex_stall, ex_mem_stall; no flushes.
  - Next state MEM_WAIT.
- State REDIRECT, mem_busy=0:
  - Asserts if_id_flush only; the stale BRAM fetch is squashed.
  - Next state RUN.
- State RUN/MEM_WAIT, mem_busy=0, ex_redirect=1:
  - Asserts if_id_flush and id_ex_flush.
  - Next state REDIRECT.
- RUN/MEM_WAIT, mem_busy=0, ex_redirect=0, lu=1:
  - Asserts pc_stall, if_id_stall, id_ex_flush (bubble insertion).
  - Next state RUN.
- Otherwise all controls are 0 and the next state is RUN.
- A redirect present while mem_busy=1 is not lost: EX is frozen, so ex_redirect stays asserted and is acted on in the first non-busy cycle.

Watchdog:
- wait_cnt (TIMEOUT_W bits) increments on each edge with mem_busy=1, saturating at all-ones.
- It clears on any edge with mem_busy=0.
- When wait_cnt reaches MEM_TIMEOUT, mem_timeout is set and stays 1 until reset.
- Pipeline behaviour is unaffected by the watchdog.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=RUN, wait_cnt=0, mem_timeout=0, perf counters 0.
  - All control outputs are 0 while reset is asserted.
- Control outputs: 0-cycle latency from their inputs, valid in the same cycle.
- Redirect costs exactly 2 bubbles: cycle N flushes IF_ID and ID_EX, cycle N+1 flushes IF_ID.
- Load-use costs exactly 1 bubble: in cycle N+1 the load has left EX, so lu deasserts without needing state.
- mem_timeout rises on the edge at which wait_cnt becomes MEM_TIMEOUT, i.e. after MEM_TIMEOUT busy edges.
- Reset mid-MEM_WAIT or mid-REDIRECT: state returns to RUN and no pending flush is retained.

## Configuration
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds 32-bit outputs stall_cycles and flush_events.
  - stall_cycles increments on each edge where pc_stall=1.
  - flush_events increments on each edge where if_id_flush=1 in state RUN/MEM_WAIT, i.e. once per redirect.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

## Test plan
- Load x5 in EX with ID reading rs1=5 -> pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly 1 cycle; with ex_rd=0, all controls stay 0.
- ex_redirect pulse at cycle 10 -> if_id_flush=1 and id_ex_flush=1 at cycle 10; only if_id_flush=1 at cycle 11; state_o=0 at cycle 12.
- mem_busy held for 5 cycles with ex_redirect=1 throughout -> all four stalls for 5 cycles with no flush, then the redirect sequence begins.
- mem_busy held with MEM_TIMEOUT=4 -> mem_timeout rises after the 4th busy edge and stays 1 after mem_busy drops.
- rst_n pulled low during REDIRECT -> state_o=0 and all outputs 0 immediately; nothing is asserted after release.
- With HAZARD_PERF_CNT_EN: 3 redirects and 2 load-use stalls -> flush_events=3, stall_cycles=2.
